// File: rtl/wb_ram_burst.sv
// Single-port Wishbone B4 RAM slave with registered-feedback bursts (CTI/BTE),
// configurable first-beat wait states and byte-lane writes.
module wb_ram_burst #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int WAIT_STATES  = 0,
    parameter bit BURST_ENABLE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o
);
    localparam int SEL_BITS = $clog2(SELECT_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - SEL_BITS;
    localparam int DEPTH    = 1 << WORD_AW;
    localparam logic [3:0]         WAIT_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [WORD_AW-1:0] ADR_ONE   = WORD_AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_r, state_n;
    logic                  ack_r, ack_n;
    logic                  err_r, err_n;
    logic [3:0]            cnt_r, cnt_n;
    logic [WORD_AW-1:0]    cur_adr_r, adr_n;
    logic [WORD_AW-1:0]    next_adr_s, rd_adr_s;
    logic [WORD_AW-1:0]    adr_word_s;
    logic                  rd_en_s;
    logic                  accept_s, reserved_s, burst_s, wr_s;
    logic [DATA_WIDTH-1:0] mem_cur_s, wr_word_s, rd_data_s;

    assign adr_word_s = adr_i[ADDR_WIDTH-1:SEL_BITS];
    // The ~err_r term keeps a held strobe from being re-accepted while err_o is high.
    assign accept_s   = cyc_i & stb_i & ~err_r;
    assign reserved_s = !((cti_i == 3'b000) || (cti_i == 3'b001) ||
                          (cti_i == 3'b010) || (cti_i == 3'b111));
    assign burst_s    = BURST_ENABLE && ((cti_i == 3'b001) || (cti_i == 3'b010));
    assign wr_s       = (state_r == ST_ACK) & cyc_i & stb_i & we_i;

    generate
        if (SEL_BITS > 0) begin : g_lsb
            logic unused_lsb_s;
            assign unused_lsb_s = ^adr_i[SEL_BITS-1:0];
        end
    endgenerate

    // Next burst address: constant, linear (wraps at depth) or wrap-4/8/16.
    always_comb begin
        next_adr_s = cur_adr_r + ADR_ONE;
        if (cti_i == 3'b001) begin
            next_adr_s = cur_adr_r;
        end else begin
            case (bte_i)
                2'b01:   next_adr_s = {cur_adr_r[WORD_AW-1:2], cur_adr_r[1:0] + 2'd1};
                2'b10:   next_adr_s = {cur_adr_r[WORD_AW-1:3], cur_adr_r[2:0] + 3'd1};
                2'b11:   next_adr_s = {cur_adr_r[WORD_AW-1:4], cur_adr_r[3:0] + 4'd1};
                default: next_adr_s = cur_adr_r + ADR_ONE;
            endcase
        end
    end

    // Byte-lane merge of write data over the current word; also the write-first bypass value.
    always_comb begin
        mem_cur_s = mem[cur_adr_r];
        wr_word_s = mem_cur_s;
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (sel_i[i]) begin
                wr_word_s[i*8 +: 8] = dat_i[i*8 +: 8];
            end else begin
                wr_word_s[i*8 +: 8] = mem_cur_s[i*8 +: 8];
            end
        end
    end

    assign rd_data_s = (wr_s && (rd_adr_s == cur_adr_r)) ? wr_word_s : mem[rd_adr_s];

    // Next-state, handshake and read-request logic.
    always_comb begin
        state_n  = state_r;
        ack_n    = ack_r;
        err_n    = 1'b0;
        cnt_n    = cnt_r;
        adr_n    = cur_adr_r;
        rd_en_s  = 1'b0;
        rd_adr_s = cur_adr_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    adr_n = adr_word_s;
                    if (BURST_ENABLE && reserved_s) begin
                        err_n = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        rd_en_s  = 1'b1;
                        rd_adr_s = adr_word_s;
                        ack_n    = 1'b1;
                        state_n  = ST_ACK;
                    end else begin
                        cnt_n   = WAIT_LOAD;
                        state_n = ST_WAIT;
                    end
                end else begin
                    ack_n = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    cnt_n   = 4'd0;
                    ack_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    rd_en_s = 1'b1;
                    ack_n   = 1'b1;
                    state_n = ST_ACK;
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                if (!cyc_i) begin
                    cnt_n   = 4'd0;
                    ack_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (stb_i) begin
                    if (burst_s) begin
                        adr_n    = next_adr_s;
                        rd_en_s  = 1'b1;
                        rd_adr_s = next_adr_s;
                    end else begin
                        ack_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end else begin
                    ack_n = ack_r;
                end
            end
            default: begin
                ack_n   = 1'b0;
                cnt_n   = 4'd0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            cnt_r     <= 4'd0;
            cur_adr_r <= '0;
            dat_o     <= '0;
        end else begin
            state_r   <= state_n;
            ack_r     <= ack_n;
            err_r     <= err_n;
            cnt_r     <= cnt_n;
            cur_adr_r <= adr_n;
            if (rd_en_s) begin
                dat_o <= rd_data_s;
            end
        end
    end

    // Memory array: byte-lane writes on beat edges, never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SELECT_WIDTH; i++) begin
            if (wr_s && sel_i[i]) begin
                mem[cur_adr_r][i*8 +: 8] <= dat_i[i*8 +: 8];
            end
        end
    end

    assign ack_o = ack_r & cyc_i & stb_i;
    assign err_o = err_r & cyc_i & stb_i;

endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed self-checking bench for wb_ram_burst: one zero-wait instance and one
// two-wait-state instance sharing the bus signals, selected by separate cyc lines.
module tb_wb_ram_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adr;
    logic [31:0] dat_w;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc0, cyc2;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat0, dat2;
    logic        ack0, ack2, err0, err2;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    wb_ram_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_STATES(0), .BURST_ENABLE(1'b1)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0), .we_i(we),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc0), .cti_i(cti), .bte_i(bte),
        .ack_o(ack0), .err_o(err0));

    wb_ram_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_STATES(2), .BURST_ENABLE(1'b1)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat2), .we_i(we),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc2), .cti_i(cti), .bte_i(bte),
        .ack_o(ack2), .err_o(err2));

    task automatic idle_bus();
        cyc0 = 1'b0; cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
        cti = 3'b000; bte = 2'b00; sel = 4'hF;
    endtask

    task automatic write0(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic read0(input logic [15:0] a, output logic [31:0] d, output logic ak);
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        ak = ack0;
        d  = dat0;
        @(negedge clk);
        idle_bus();
    endtask

    // Classic access on the two-wait-state instance; lat = cycles from accept to ack (0 = none).
    task automatic ws2_access(input logic w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] s, output int lat, output logic [31:0] rd);
        @(negedge clk);
        cyc2 = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack2 === 1'b1) begin
                lat = i;
                rd  = dat2;
                break;
            end
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err0); end
        total++; if (dat0 !== 32'h0) begin bad++; $display("FAIL reset_dat0 got=%h exp=0", dat0); end
        total++; if (dat2 !== 32'h0) begin bad++; $display("FAIL reset_dat2 got=%h exp=0", dat2); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_classic();
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0010; dat_w = 32'hDEADBEEF; sel = 4'hF;
        cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL classic_wr_ack got=%b exp=1", ack0); end
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL classic_wr_ack_low got=%b exp=0", ack0); end
        we = 1'b0; dat_w = 32'h0;
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL classic_rd_ack got=%b exp=1", ack0); end
        total++; if (dat0 !== 32'hDEADBEEF) begin bad++; $display("FAIL classic_rd_data got=%h exp=deadbeef", dat0); end
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL classic_rd_ack_low got=%b exp=0", ack0); end
        idle_bus();
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [31:0] rd;
        ws2_access(1'b1, 16'h0020, 32'hAABBCCDD, 4'hF, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL ws2_full_wr_latency got=%0d exp=3", lat); end
        ws2_access(1'b1, 16'h0020, 32'h11223344, 4'b0101, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL ws2_lane_wr_latency got=%0d exp=3", lat); end
        ws2_access(1'b0, 16'h0020, 32'h0, 4'hF, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL ws2_rd_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hAA22CC44) begin bad++; $display("FAIL ws2_lane_data got=%h exp=aa22cc44", rd); end
    endtask

    task automatic test_linear_burst();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h3FFE; exp_d[1] = 32'h3FFF; exp_d[2] = 32'h0; exp_d[3] = 32'h1;
        write0(16'hFFF8, 32'h3FFE, 4'hF);
        write0(16'hFFFC, 32'h3FFF, 4'hF);
        write0(16'h0000, 32'h0000, 4'hF);
        write0(16'h0004, 32'h0001, 4'hF);
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'hFFF8; cti = 3'b010; bte = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            adr = 16'h1234;
            total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL lin_ack beat=%0d got=%b exp=1", i, ack0); end
            total++; if (dat0 !== exp_d[i]) begin bad++; $display("FAIL lin_data beat=%0d got=%h exp=%h", i, dat0, exp_d[i]); end
            if (i == 3) cti = 3'b111;
        end
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL lin_ack_end got=%b exp=0", ack0); end
        idle_bus();
    endtask

    task automatic test_wrap4();
        logic [31:0] rd;
        logic ak;
        logic [31:0] exp_d [5];
        exp_d[0] = 32'h4; exp_d[1] = 32'h1; exp_d[2] = 32'h2; exp_d[3] = 32'h3; exp_d[4] = 32'hFFFFFFFF;
        write0(16'h0020, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0014; dat_w = 32'h1; sel = 4'hF;
        cti = 3'b010; bte = 2'b01;
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL wrap_ack1 got=%b exp=1", ack0); end
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL wrap_ack2 got=%b exp=1", ack0); end
        dat_w = 32'h2;
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL wrap_ack3 got=%b exp=1", ack0); end
        dat_w = 32'h3; stb = 1'b0;
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL wrap_stall_ack1 got=%b exp=0", ack0); end
        dat_w = 32'h00000BAD;
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL wrap_stall_ack2 got=%b exp=0", ack0); end
        dat_w = 32'h3; stb = 1'b1;
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL wrap_resume_ack got=%b exp=1", ack0); end
        dat_w = 32'h4; cti = 3'b111;
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL wrap_end_ack got=%b exp=0", ack0); end
        idle_bus();
        for (int i = 0; i < 5; i++) begin
            read0(16'(16'h0010 + 16'(i * 4)), rd, ak);
            total++;
            if (ak !== 1'b1 || rd !== exp_d[i]) begin
                bad++; $display("FAIL wrap_mem word=%0d got=%h ack=%b exp=%h", 4 + i, rd, ak, exp_d[i]);
            end
        end
    endtask

    task automatic test_const_bypass();
        logic [31:0] rd;
        logic ak;
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0020; dat_w = 32'h000000A5; sel = 4'b0001;
        cti = 3'b001; bte = 2'b00;
        @(negedge clk);
        total++; if (dat0 !== 32'hFFFFFFFF) begin bad++; $display("FAIL const_first_data got=%h exp=ffffffff", dat0); end
        @(negedge clk);
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL const_ack got=%b exp=1", ack0); end
        total++; if (dat0 !== 32'hFFFFFFA5) begin bad++; $display("FAIL const_bypass got=%h exp=ffffffa5", dat0); end
        we = 1'b0; cti = 3'b111;
        @(negedge clk);
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL const_end_ack got=%b exp=0", ack0); end
        idle_bus();
        read0(16'h0020, rd, ak);
        total++; if (rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL const_mem got=%h exp=ffffffa5", rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic ak;
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0010; dat_w = 32'h12345678; sel = 4'hF;
        cti = 3'b011; bte = 2'b00;
        @(negedge clk);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL err_ws0 got=%b exp=1", err0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL err_ws0_ack got=%b exp=0", ack0); end
        @(negedge clk);
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL err_ws0_one_cycle got=%b exp=0", err0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL err_ws0_no_ack got=%b exp=0", ack0); end
        idle_bus();
        read0(16'h0010, rd, ak);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL err_mem_unchanged got=%h exp=4", rd); end
        @(negedge clk);
        cyc2 = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0020; cti = 3'b011;
        @(negedge clk);
        total++; if (err2 !== 1'b1) begin bad++; $display("FAIL err_ws2 got=%b exp=1", err2); end
        @(negedge clk);
        total++; if (err2 !== 1'b0 || ack2 !== 1'b0) begin bad++; $display("FAIL err_ws2_after got=%b/%b exp=0/0", err2, ack2); end
        idle_bus();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] rd;
        logic ak;
        @(negedge clk);
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0010; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        total++; if (dat0 !== 32'h4) begin bad++; $display("FAIL rst_burst_beat0 got=%h exp=4", dat0); end
        @(negedge clk);
        total++; if (dat0 !== 32'h1 || ack0 !== 1'b1) begin bad++; $display("FAIL rst_burst_beat1 got=%h ack=%b exp=1", dat0, ack0); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b exp=0", ack0); end
        total++; if (dat0 !== 32'h0) begin bad++; $display("FAIL rst_mid_dat got=%h exp=0", dat0); end
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        read0(16'h0014, rd, ak);
        total++; if (rd !== 32'h1 || ak !== 1'b1) begin bad++; $display("FAIL rst_keep_w5 got=%h ack=%b exp=1", rd, ak); end
        read0(16'h0010, rd, ak);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL rst_keep_w4 got=%h exp=4", rd); end
    endtask

    initial begin
        rst_n = 1'b1;
        adr   = 16'h0;
        dat_w = 32'h0;
        idle_bus();
        test_reset();
        test_classic();
        test_byte_lanes();
        test_linear_burst();
        test_wrap4();
        test_const_bypass();
        test_error();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
